// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer: combinational lookup for fetch and a
// single training port from execute. Define BTB_STATS_EN to enable the event counters.
module branch_target_buffer #(
  parameter int ENTRIES  = 16,
  parameter int PC_WIDTH = 16,
  parameter int CTR_BITS = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [PC_WIDTH-1:0] fetch_pc,
  input  logic                lookup_en,
  output logic                pred_hit,
  output logic                pred_taken,
  output logic [PC_WIDTH-1:0] pred_target,
  input  logic                upd_valid,
  input  logic [PC_WIDTH-1:0] upd_pc,
  input  logic                upd_taken,
  input  logic [PC_WIDTH-1:0] upd_target,
  input  logic                upd_mispredict,
  input  logic                flush,
  output logic [15:0]         stat_lookups,
  output logic [15:0]         stat_hits,
  output logic [15:0]         stat_mispredicts
);

  localparam int INDEX_BITS = $clog2(ENTRIES);
  localparam int TAG_BITS   = PC_WIDTH - INDEX_BITS;

  localparam logic [CTR_BITS-1:0] CTR_MAX     = '1;
  localparam logic [CTR_BITS-1:0] CTR_WEAK_T  = CTR_BITS'(1) << (CTR_BITS - 1);
  localparam logic [CTR_BITS-1:0] CTR_WEAK_NT = CTR_WEAK_T - CTR_BITS'(1);

  logic [ENTRIES-1:0]  r_valid;
  logic [TAG_BITS-1:0] r_tag    [ENTRIES];
  logic [PC_WIDTH-1:0] r_target [ENTRIES];
  logic [CTR_BITS-1:0] r_ctr    [ENTRIES];

  logic [INDEX_BITS-1:0] w_fetch_idx;
  logic [TAG_BITS-1:0]   w_fetch_tag;
  logic [INDEX_BITS-1:0] w_upd_idx;
  logic [TAG_BITS-1:0]   w_upd_tag;
  logic                  w_upd_hit;

  assign w_fetch_idx = fetch_pc[INDEX_BITS-1:0];
  assign w_fetch_tag = fetch_pc[PC_WIDTH-1:INDEX_BITS];
  assign w_upd_idx   = upd_pc[INDEX_BITS-1:0];
  assign w_upd_tag   = upd_pc[PC_WIDTH-1:INDEX_BITS];
  assign w_upd_hit   = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);

  // Lookup reads only registered state, so a same-cycle update is seen next cycle.
  assign pred_hit    = r_valid[w_fetch_idx] && (r_tag[w_fetch_idx] == w_fetch_tag);
  assign pred_taken  = pred_hit && r_ctr[w_fetch_idx][CTR_BITS-1];
  assign pred_target = pred_taken ? r_target[w_fetch_idx] : fetch_pc + PC_WIDTH'(1);

  // NOTE: the table is reset entry by entry because counters must come out of
  // reset weakly not-taken; this forces flops rather than a RAM macro.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= CTR_WEAK_NT;
      end
    end else if (flush) begin
      r_valid <= '0;
    end else if (upd_valid) begin
      if (w_upd_hit) begin
        if (upd_taken) begin
          r_target[w_upd_idx] <= upd_target;
          if (r_ctr[w_upd_idx] != CTR_MAX) r_ctr[w_upd_idx] <= r_ctr[w_upd_idx] + CTR_BITS'(1);
        end else if (r_ctr[w_upd_idx] != '0) begin
          r_ctr[w_upd_idx] <= r_ctr[w_upd_idx] - CTR_BITS'(1);
        end
      end else if (upd_taken) begin
        r_valid[w_upd_idx]  <= 1'b1;
        r_tag[w_upd_idx]    <= w_upd_tag;
        r_target[w_upd_idx] <= upd_target;
        r_ctr[w_upd_idx]    <= CTR_WEAK_T;
      end
    end
  end

`ifdef BTB_STATS_EN
  logic [15:0] r_stat_lookups;
  logic [15:0] r_stat_hits;
  logic [15:0] r_stat_mispredicts;

  // Counters saturate and survive flush; only reset clears them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stat_lookups     <= '0;
      r_stat_hits        <= '0;
      r_stat_mispredicts <= '0;
    end else begin
      if (lookup_en && r_stat_lookups != 16'hFFFF)
        r_stat_lookups <= r_stat_lookups + 16'd1;
      if (lookup_en && pred_hit && r_stat_hits != 16'hFFFF)
        r_stat_hits <= r_stat_hits + 16'd1;
      if (upd_valid && upd_mispredict && r_stat_mispredicts != 16'hFFFF)
        r_stat_mispredicts <= r_stat_mispredicts + 16'd1;
    end
  end

  assign stat_lookups     = r_stat_lookups;
  assign stat_hits        = r_stat_hits;
  assign stat_mispredicts = r_stat_mispredicts;
`else
  logic w_unused_stats;
  assign w_unused_stats   = lookup_en ^ upd_mispredict;
  assign stat_lookups     = '0;
  assign stat_hits        = '0;
  assign stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed bench for branch_target_buffer: allocation, counter training,
// wrap, bypass timing, flush, reset and (with BTB_STATS_EN) statistics.
module tb_branch_target_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] fetch_pc;
  logic        lookup_en;
  logic        pred_hit;
  logic        pred_taken;
  logic [15:0] pred_target;
  logic        upd_valid;
  logic [15:0] upd_pc;
  logic        upd_taken;
  logic [15:0] upd_target;
  logic        upd_mispredict;
  logic        flush;
  logic [15:0] stat_lookups;
  logic [15:0] stat_hits;
  logic [15:0] stat_mispredicts;

  int n_checks = 0;
  int n_errors = 0;

  branch_target_buffer #(.ENTRIES(16), .PC_WIDTH(16), .CTR_BITS(2)) dut (
    .clk(clk), .reset(reset), .fetch_pc(fetch_pc), .lookup_en(lookup_en),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_mispredict(upd_mispredict), .flush(flush),
    .stat_lookups(stat_lookups), .stat_hits(stat_hits),
    .stat_mispredicts(stat_mispredicts)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look(input logic [15:0] pc);
    fetch_pc = pc;
    #1;
  endtask

  task automatic expect_pred(input string tag, input logic [15:0] pc,
                             input logic hit, input logic tkn, input logic [15:0] tgt);
    look(pc);
    check({tag, ".hit"},    32'(pred_hit),    32'(hit));
    check({tag, ".taken"},  32'(pred_taken),  32'(tkn));
    check({tag, ".target"}, 32'(pred_target), 32'(tgt));
  endtask

  task automatic update(input logic [15:0] pc, input logic tkn, input logic [15:0] tgt);
    upd_valid  = 1'b1;
    upd_pc     = pc;
    upd_taken  = tkn;
    upd_target = tgt;
    tick();
    upd_valid  = 1'b0;
  endtask

  task automatic expect_stats(input string tag, input logic [15:0] l,
                              input logic [15:0] h, input logic [15:0] m);
    check({tag, ".lookups"},     32'(stat_lookups),     32'(l));
    check({tag, ".hits"},        32'(stat_hits),        32'(h));
    check({tag, ".mispredicts"}, 32'(stat_mispredicts), 32'(m));
  endtask

  initial begin
    reset = 1'b1; fetch_pc = 16'h0040; lookup_en = 1'b0;
    upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
    upd_mispredict = 1'b0; flush = 1'b0;
    tick();
    tick();
    expect_pred("reset_lookup", 16'h0040, 1'b0, 1'b0, 16'h0041);
    expect_stats("reset_stats", 16'd0, 16'd0, 16'd0);
    reset = 1'b0;
    tick();
    expect_pred("post_reset", 16'h0040, 1'b0, 1'b0, 16'h0041);

    // Allocation, then a same-index alias with a different tag.
    update(16'h0043, 1'b1, 16'h0100);
    expect_pred("alloc", 16'h0043, 1'b1, 1'b1, 16'h0100);
    expect_pred("alias_miss", 16'h0013, 1'b0, 1'b0, 16'h0014);

    // Counter training on 0x0043, starting at 2; not-taken never rewrites target.
    update(16'h0043, 1'b0, 16'h0300);
    expect_pred("nt1_ctr1", 16'h0043, 1'b1, 1'b0, 16'h0044);
    update(16'h0043, 1'b0, 16'h0300);
    update(16'h0043, 1'b0, 16'h0300);
    expect_pred("nt3_ctr0_sat", 16'h0043, 1'b1, 1'b0, 16'h0044);
    update(16'h0043, 1'b1, 16'h0100);
    expect_pred("t1_ctr1", 16'h0043, 1'b1, 1'b0, 16'h0044);
    update(16'h0043, 1'b1, 16'h0200);
    expect_pred("t2_ctr2_newtgt", 16'h0043, 1'b1, 1'b1, 16'h0200);
    update(16'h0043, 1'b1, 16'h0200);
    update(16'h0043, 1'b1, 16'h0200);
    expect_pred("t4_ctr3_sat", 16'h0043, 1'b1, 1'b1, 16'h0200);
    update(16'h0043, 1'b0, 16'h0300);
    expect_pred("nt_ctr2", 16'h0043, 1'b1, 1'b1, 16'h0200);
    update(16'h0043, 1'b0, 16'h0300);
    expect_pred("nt_ctr1", 16'h0043, 1'b1, 1'b0, 16'h0044);

    // PC wrap on a miss; not-taken update to an empty index allocates nothing.
    expect_pred("wrap", 16'hFFFF, 1'b0, 1'b0, 16'h0000);
    update(16'h0025, 1'b0, 16'h0555);
    expect_pred("nt_no_alloc", 16'h0025, 1'b0, 1'b0, 16'h0026);

    // Same-cycle update and lookup: old result now, new result after the edge.
    fetch_pc = 16'h0050;
    upd_valid = 1'b1; upd_pc = 16'h0050; upd_taken = 1'b1; upd_target = 16'h0777;
    #1;
    check("bypass_old.hit", 32'(pred_hit), 32'd0);
    check("bypass_old.target", 32'(pred_target), 32'h0051);
    tick();
    upd_valid = 1'b0;
    expect_pred("bypass_new", 16'h0050, 1'b1, 1'b1, 16'h0777);

    // Flush wins over a same-cycle allocation.
    flush = 1'b1;
    update(16'h0066, 1'b1, 16'h0123);
    flush = 1'b0;
    expect_pred("flush_upd", 16'h0066, 1'b0, 1'b0, 16'h0067);
    expect_pred("flush_0043", 16'h0043, 1'b0, 1'b0, 16'h0044);
    expect_pred("flush_0050", 16'h0050, 1'b0, 1'b0, 16'h0051);
    update(16'h0050, 1'b1, 16'h0888);
    expect_pred("realloc", 16'h0050, 1'b1, 1'b1, 16'h0888);

    // Asynchronous reset mid-cycle, held across an edge carrying an update.
    look(16'h0050);
    reset = 1'b1;
    #1;
    check("async_reset.hit", 32'(pred_hit), 32'd0);
    check("async_reset.target", 32'(pred_target), 32'h0051);
    update(16'h0043, 1'b1, 16'h0999);
    reset = 1'b0;
    tick();
    expect_pred("reset_discard", 16'h0043, 1'b0, 1'b0, 16'h0044);
    update(16'h0050, 1'b1, 16'h0888);
    expect_pred("after_reset_alloc", 16'h0050, 1'b1, 1'b1, 16'h0888);

    // Statistics: 5 lookups (2 hits), 1 mispredict report.
    lookup_en = 1'b1;
    look(16'h0050); tick();
    look(16'h0051); tick();
    look(16'h0050); tick();
    look(16'h0060);
    upd_valid = 1'b1; upd_pc = 16'h0099; upd_taken = 1'b0; upd_mispredict = 1'b1;
    tick();
    upd_valid = 1'b0; upd_mispredict = 1'b0;
    look(16'h0070); tick();
    lookup_en = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
`ifdef BTB_STATS_EN
    expect_stats("stats_5_2_1", 16'd5, 16'd2, 16'd1);
    update(16'h0050, 1'b1, 16'h0888);
    lookup_en = 1'b1; upd_valid = 1'b1; upd_pc = 16'h00A9; upd_taken = 1'b0;
    upd_mispredict = 1'b1; fetch_pc = 16'h0050;
    for (int i = 0; i < 65540; i++) tick();
    expect_stats("stats_sat", 16'hFFFF, 16'hFFFF, 16'hFFFF);
    tick();
    tick();
    expect_stats("stats_hold", 16'hFFFF, 16'hFFFF, 16'hFFFF);
    lookup_en = 1'b0; upd_valid = 1'b0; upd_mispredict = 1'b0;
`else
    expect_stats("stats_off", 16'd0, 16'd0, 16'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
